// File: rtl/opl2_host_if.sv
// opl2_host_if: host bus decode, write FIFO and paced opl2_reg_wr issue; OPL2_HOST_IF_DROP_COUNT_EN adds drop_count.
module opl2_host_if #(
    parameter int FIFO_DEPTH    = 4,
    parameter int WR_GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_cs_n,
    input  logic       host_wr_n,
    input  logic       host_rd_n,
    input  logic       host_a0,
    input  logic [7:0] host_din,
    output logic [7:0] host_dout,
    input  logic [7:0] status,
    output logic       opl2_reg_wr_valid,
    output logic [7:0] opl2_reg_wr_address,
    output logic [7:0] opl2_reg_wr_data,
`ifdef OPL2_HOST_IF_DROP_COUNT_EN
    output logic [7:0] drop_count,
`endif
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    state_t state, state_nx;
    logic [15:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic [7:0] addr_latch, gap_cnt, rd_hi;
    logic wr_n_q, rd_n_q, wr_ev, rd_ev, full, empty, push, pop;
    assign wr_ev = wr_n_q & ~host_wr_n & ~host_cs_n;
    assign rd_ev = rd_n_q & ~host_rd_n & ~host_cs_n;
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push  = wr_ev & host_a0 & ~full;
    assign pop   = (state == IDLE) & ~empty;
    assign busy  = ~empty | (state != IDLE);
`ifdef OPL2_HOST_IF_DROP_COUNT_EN
    assign rd_hi = drop_count;
`else
    assign rd_hi = 8'hFF;
`endif
    always_comb begin
        state_nx = state;
        if (pop)
            state_nx = ISSUE;
        else if (state == ISSUE)
            state_nx = (WR_GAP_CYCLES == 0) ? IDLE : GAP;
        else if (state == GAP && gap_cnt == 8'd0)
            state_nx = IDLE;
    end
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    always_ff @(posedge clk)
        if (push)
            mem[wptr[AW-1:0]] <= {addr_latch, host_din};
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_n_q              <= 1'b0;
            rd_n_q              <= 1'b0;
            addr_latch          <= 8'd0;
            wptr                <= '0;
            rptr                <= '0;
            gap_cnt             <= 8'd0;
            opl2_reg_wr_valid   <= 1'b0;
            opl2_reg_wr_address <= 8'd0;
            opl2_reg_wr_data    <= 8'd0;
            host_dout           <= 8'd0;
        end else begin
            wr_n_q <= host_wr_n;
            rd_n_q <= host_rd_n;
            if (wr_ev && !host_a0)
                addr_latch <= host_din;
            if (push)
                wptr <= wptr + PTR_ONE;
            if (pop) begin
                rptr <= rptr + PTR_ONE;
                {opl2_reg_wr_address, opl2_reg_wr_data} <= mem[rptr[AW-1:0]];
            end
            opl2_reg_wr_valid <= pop;
            // Counter runs only in GAP; it is loaded while still in ISSUE.
            if (state == ISSUE && WR_GAP_CYCLES != 0)
                gap_cnt <= 8'(WR_GAP_CYCLES - 1);
            else if (state == GAP && gap_cnt != 8'd0)
                gap_cnt <= gap_cnt - 8'd1;
            if (rd_ev)
                host_dout <= host_a0 ? rd_hi : status;
        end
    end
`ifdef OPL2_HOST_IF_DROP_COUNT_EN
    always_ff @(posedge clk)
        if (reset)
            drop_count <= 8'd0;
        else if (wr_ev && host_a0 && full && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
`endif
endmodule

// File: tb/tb_opl2_host_if.sv
// tb_opl2_host_if: directed checks of host decode, FIFO pacing, overflow, reads and reset.
module tb_opl2_host_if;
    logic clk = 1'b0, reset = 1'b1;
    logic host_cs_n = 1'b0, host_wr_n = 1'b1, host_rd_n = 1'b1, host_a0 = 1'b0;
    logic [7:0] host_din = 8'd0, status = 8'd0;
    logic [7:0] host_dout, opl2_reg_wr_address, opl2_reg_wr_data;
    logic opl2_reg_wr_valid, busy;
`ifdef OPL2_HOST_IF_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif
    int cyc = 0, checks = 0, errors = 0;
    int pc[$];
    logic [15:0] pd[$];
    int e, e1, d;

    opl2_host_if dut (
        .clk(clk), .reset(reset), .host_cs_n(host_cs_n), .host_wr_n(host_wr_n),
        .host_rd_n(host_rd_n), .host_a0(host_a0), .host_din(host_din),
        .host_dout(host_dout), .status(status), .opl2_reg_wr_valid(opl2_reg_wr_valid),
        .opl2_reg_wr_address(opl2_reg_wr_address), .opl2_reg_wr_data(opl2_reg_wr_data),
`ifdef OPL2_HOST_IF_DROP_COUNT_EN
        .drop_count(drop_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (opl2_reg_wr_valid) begin
            pc.push_back(cyc);
            pd.push_back({opl2_reg_wr_address, opl2_reg_wr_data});
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic a0, input logic [7:0] dat, output int ev);
        @(negedge clk);
        host_a0 = a0; host_din = dat; host_wr_n = 1'b0; ev = cyc;
        @(negedge clk);
        host_wr_n = 1'b1;
    endtask

    task automatic rd(input logic a0, input logic [7:0] exp, input string tag);
        @(negedge clk);
        host_a0 = a0; host_rd_n = 1'b0;
        @(negedge clk);
        host_rd_n = 1'b1;
        chk(tag, host_dout, exp);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic clr();
        pc.delete(); pd.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", opl2_reg_wr_valid, 0);
        chk("rst_addr", opl2_reg_wr_address, 0);
        chk("rst_data", opl2_reg_wr_data, 0);
        chk("rst_dout", host_dout, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        clr();
        wr(1'b0, 8'h04, e);
        wr(1'b1, 8'h80, e);
        wait_until(e + 3);
        chk("t1_valid_drop", opl2_reg_wr_valid, 0);
        chk("t1_addr_hold", opl2_reg_wr_address, 8'h04);
        wait_until(e + 10);
        chk("t1_busy_gap", busy, 1);
        wait_until(e + 11);
        chk("t1_busy_idle", busy, 0);
        chk("t1_count", pc.size(), 1);
        chk("t1_lat", pc[0], e + 2);
        chk("t1_word", pd[0], 16'h0480);

        clr();
        wr(1'b0, 8'h20, e);
        wr(1'b1, 8'h01, e1);
        wr(1'b1, 8'h02, e);
        wr(1'b1, 8'h03, e);
        wait_until(e1 + 35);
        chk("t2_count", pc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_cyc", pc[i], e1 + 2 + 10 * i);
            chk("t2_word", pd[i], {8'h20, 8'(i + 1)});
        end

        clr();
        wr(1'b0, 8'h33, e);
        wr(1'b1, 8'h10, e1);
        for (int i = 1; i < 6; i++) wr(1'b1, 8'(8'h10 + i), e);
        wait_until(e1 + 60);
        chk("t3_count", pc.size(), 5);
        for (int i = 0; i < 5; i++) chk("t3_word", pd[i], {8'h33, 8'(8'h10 + i)});
        chk("t3_busy", busy, 0);

        status = 8'hE0;
        rd(1'b0, 8'hE0, "t4_status_e0");
        status = 8'h5A;
        rd(1'b0, 8'h5A, "t4_status_5a");
`ifdef OPL2_HOST_IF_DROP_COUNT_EN
        rd(1'b1, 8'h01, "t4_drop_rd");
        chk("t4_drop_port", drop_count, 8'h01);
`else
        rd(1'b1, 8'hFF, "t4_a1_rd");
`endif
        status = 8'h11;
        repeat (3) @(negedge clk);
`ifdef OPL2_HOST_IF_DROP_COUNT_EN
        chk("t4_dout_hold", host_dout, 8'h01);
`else
        chk("t4_dout_hold", host_dout, 8'hFF);
`endif

        clr();
        @(negedge clk);
        host_a0 = 1'b1; host_din = 8'h55; host_wr_n = 1'b0; e = cyc;
        repeat (20) @(negedge clk);
        host_wr_n = 1'b1;
        wait_until(e + 30);
        chk("t5_count", pc.size(), 1);
        chk("t5_lat", pc[0], e + 2);
        chk("t5_word", pd[0], 16'h3355);

        clr();
        @(negedge clk);
        host_cs_n = 1'b1; host_a0 = 1'b1; host_din = 8'h77; host_wr_n = 1'b0;
        @(negedge clk);
        host_wr_n = 1'b1;
        @(negedge clk);
        host_cs_n = 1'b0;
        repeat (15) @(negedge clk);
        chk("t6_cs_count", pc.size(), 0);

        wr(1'b0, 8'h40, e);
        wr(1'b1, 8'h01, e1);
        for (int i = 2; i < 5; i++) wr(1'b1, 8'(i), e);
        chk("t7_busy_pre", busy, 1);
        @(negedge clk);
        reset = 1'b1; host_wr_n = 1'b0; host_a0 = 1'b1; host_din = 8'h99;
        @(negedge clk);
        reset = 1'b0;
        chk("t7_valid", opl2_reg_wr_valid, 0);
        chk("t7_busy", busy, 0);
        chk("t7_dout", host_dout, 0);
        chk("t7_addr", opl2_reg_wr_address, 0);
`ifdef OPL2_HOST_IF_DROP_COUNT_EN
        chk("t7_drop", drop_count, 0);
`endif
        clr();
        repeat (5) @(negedge clk);
        host_wr_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("t7_count", pc.size(), 0);
        chk("t7_busy_end", busy, 0);

        clr();
        wr(1'b1, 8'hAB, e);
        wait_until(e + 5);
        chk("t8_count", pc.size(), 1);
        chk("t8_word", pd[0], 16'h00AB);

        d = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
